alu_req_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two requesters (port 0, port 1) using round-robin arbitration.
- Per granted request, the block drives numLeft/numRight/opChoose onto the ALU. It then pulses the ALU's three latch strobes, waits for the result to settle, captures it, and returns it to the requester with an ID tag.
- Sits between the requester logic and the ALU. It is the only driver of the ALU's input and strobe pins.

---
 rtl/alu_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one latched 8-bit ALU.
// Optional result cache for repeated operand triples: define ALU_REQ_CACHE_EN.
module alu_req_arbiter #(
  parameter int STROBE_CYCLES = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid0,
  input  logic       reqValid1,
  output logic       reqReady0,
  output logic       reqReady1,
  input  logic [7:0] reqLeft0,
  input  logic [7:0] reqLeft1,
  input  logic [7:0] reqRight0,
  input  logic [7:0] reqRight1,
  input  logic [7:0] reqOp0,
  input  logic [7:0] reqOp1,
  output logic       rspValid,
  output logic       rspId,
  output logic [7:0] rspData,
  output logic       busy,
  output logic [7:0] aluNumLeft,
  output logic [7:0] aluNumRight,
  output logic [7:0] aluOpChoose,
  output logic       aluClkNumLeft,
  output logic       aluClkNumRight,
  output logic       aluClkOpChoose,
  input  logic [7:0] aluResult
);

  localparam int MAX_CYCLES = (STROBE_CYCLES > SETTLE_CYCLES) ? STROBE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last_grant, grant, accept, hit, id;
  logic [7:0]    sel_left, sel_right, sel_op, hit_data;

  always_comb begin
    grant = 1'b0;
    if (reqValid0 && reqValid1) begin
      grant = ~last_grant;
    end else if (reqValid1) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  assign reqReady0 = (state == IDLE) && !rst && reqValid0 && !grant;
  assign reqReady1 = (state == IDLE) && !rst && reqValid1 && grant;
  assign accept    = reqReady0 || reqReady1;
  assign sel_left  = grant ? reqLeft1  : reqLeft0;
  assign sel_right = grant ? reqRight1 : reqRight0;
  assign sel_op    = grant ? reqOp1    : reqOp0;

`ifdef ALU_REQ_CACHE_EN
  logic        cache_valid;
  logic [23:0] cache_key;
  logic [7:0]  cache_result;

  assign hit      = cache_valid && ({sel_left, sel_right, sel_op} == cache_key);
  assign hit_data = cache_result;

  // Only a transaction that actually ran through the ALU refreshes the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid  <= 1'b0;
      cache_key    <= 24'd0;
      cache_result <= 8'd0;
    end else if (state_nx == CAPTURE && state != IDLE) begin
      cache_valid  <= 1'b1;
      cache_key    <= {aluNumLeft, aluNumRight, aluOpChoose};
      cache_result <= aluResult;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'd0;
`endif

  // One down-counter times both the strobe and the settle windows.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = hit ? CAPTURE : SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = STROBE_LOAD;
      end
      STROBE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (SETTLE_CYCLES == 0) begin
          state_nx = CAPTURE;
        end else begin
          state_nx = SETTLE;
          cnt_nx   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= 1'b0;
      aluClkNumLeft  <= 1'b0;
      aluClkNumRight <= 1'b0;
      aluClkOpChoose <= 1'b0;
      rspValid       <= 1'b0;
      rspData        <= 8'd0;
      rspId          <= 1'b0;
      aluNumLeft     <= 8'd0;
      aluNumRight    <= 8'd0;
      aluOpChoose    <= 8'd0;
      id             <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      busy           <= (state_nx != IDLE);
      aluClkNumLeft  <= (state_nx == STROBE);
      aluClkNumRight <= (state_nx == STROBE);
      aluClkOpChoose <= (state_nx == STROBE);
      rspValid       <= (state_nx == CAPTURE);
      if (accept) begin
        id         <= grant;
        last_grant <= grant;
        if (!hit) begin
          aluNumLeft  <= sel_left;
          aluNumRight <= sel_right;
          aluOpChoose <= sel_op;
        end
      end
      // Entering CAPTURE straight from IDLE can only be a cache hit.
      if (state_nx == CAPTURE && state != CAPTURE) begin
        rspData <= (state == IDLE) ? hit_data : aluResult;
        rspId   <= (state == IDLE) ? grant : id;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: default and STROBE=3/SETTLE=0 instances against a timeline model.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    return (op == 8'h11) ? (a + b) : (a ^ b ^ op);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S   = (g == 0) ? 1 : 3;
    localparam int T   = (g == 0) ? 2 : 0;
    localparam int LAT = 2 + S + T;

    logic       rst, v0, v1, rdy0, rdy1, rsp_v, rsp_id, busy, ck_l, ck_r, ck_o;
    logic [7:0] l0, r0, o0, l1, r1, o1, rsp_d, a_l, a_r, a_o, a_res, m_l, m_r, m_o;

    alu_req_arbiter #(.STROBE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .reqValid0(v0), .reqValid1(v1), .reqReady0(rdy0), .reqReady1(rdy1),
      .reqLeft0(l0), .reqLeft1(l1), .reqRight0(r0), .reqRight1(r1),
      .reqOp0(o0), .reqOp1(o1),
      .rspValid(rsp_v), .rspId(rsp_id), .rspData(rsp_d), .busy(busy),
      .aluNumLeft(a_l), .aluNumRight(a_r), .aluOpChoose(a_o),
      .aluClkNumLeft(ck_l), .aluClkNumRight(ck_r), .aluClkOpChoose(ck_o),
      .aluResult(a_res)
    );

    // Latched ALU: each operand register captures on its own strobe.
    always @(posedge ck_l) m_l <= a_l;
    always @(posedge ck_r) m_r <= a_r;
    always @(posedge ck_o) m_o <= a_o;
    assign a_res = alu_fn(m_l, m_r, m_o);

    int          k = 0;
    int          free_at, acc, lat;
    bit          hit, lg, exp_id, last_id, idle, gs, er0, er1, exp_stb, fired0, fired1, done, got;
    logic [7:0]  exp_data, last_data, e_al, e_ar, e_ao;
    logic [23:0] pend_t;
`ifdef ALU_REQ_CACHE_EN
    bit          cv;
    logic [23:0] ct;
    logic [7:0]  cd;
`endif
    int          grant_k[$];
    bit          grant_id[$];
    int          rsp_k[$];
    logic [7:0]  rsp_dq[$];
    bit          rsp_iq[$];

    // Timeline model: an accepted op at cycle A owns cycles A+1..A+lat.
    always @(posedge clk) begin
      #3;
      if (rst) begin
        chk("rst_ctrl", {rdy0, rdy1, rsp_v, rsp_id, busy, ck_l, ck_r, ck_o}, 32'd0);
        chk("rst_data", {rsp_d, a_l, a_r, a_o}, 32'd0);
        free_at = k + 1; acc = -1000; lat = LAT; hit = 1'b0; lg = 1'b1;
        last_data = 8'd0; last_id = 1'b0; exp_data = 8'd0; exp_id = 1'b0;
        e_al = 8'd0; e_ar = 8'd0; e_ao = 8'd0;
`ifdef ALU_REQ_CACHE_EN
        cv = 1'b0;
`endif
      end else begin
        if (k == acc + lat) begin
          last_data = exp_data;
          last_id   = exp_id;
`ifdef ALU_REQ_CACHE_EN
          if (!hit) begin cv = 1'b1; ct = pend_t; cd = exp_data; end
`endif
        end
        idle = (k >= free_at);
        gs   = (v0 && v1) ? !lg : v1;
        er0  = idle && v0 && !gs;
        er1  = idle && v1 && gs;
        exp_stb = !hit && (k >= acc + 2) && (k <= acc + 1 + S);
        chk("reqReady0", rdy0, er0);
        chk("reqReady1", rdy1, er1);
        chk("busy", busy, (k > acc) && (k <= acc + lat));
        chk("strobes", {ck_l, ck_r, ck_o}, {3{exp_stb}});
        chk("rspValid", rsp_v, k == acc + lat);
        chk("rspData", rsp_d, last_data);
        chk("rspId", rsp_id, last_id);
        chk("alu_inputs", {a_l, a_r, a_o}, {e_al, e_ar, e_ao});
        if (er0 || er1) begin
          acc    = k;
          exp_id = gs;
          lg     = gs;
          pend_t = gs ? {l1, r1, o1} : {l0, r0, o0};
`ifdef ALU_REQ_CACHE_EN
          hit = cv && (pend_t == ct);
          exp_data = hit ? cd : alu_fn(pend_t[23:16], pend_t[15:8], pend_t[7:0]);
`else
          hit = 1'b0;
          exp_data = alu_fn(pend_t[23:16], pend_t[15:8], pend_t[7:0]);
`endif
          lat = hit ? 1 : LAT;
          if (!hit) {e_al, e_ar, e_ao} = pend_t;
          free_at = k + lat + 1;
        end
      end
      fired0 = v0 && rdy0;
      fired1 = v1 && rdy1;
      if (fired0 || fired1) begin grant_k.push_back(k); grant_id.push_back(fired1); end
      if (rsp_v) begin rsp_k.push_back(k); rsp_dq.push_back(rsp_d); rsp_iq.push_back(rsp_id); end
      k++;
    end

    task automatic wait_fire(input bit p, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 80; n++) begin
        @(posedge clk); #1;
        if (p ? fired1 : fired0) begin ok = 1'b1; break; end
      end
    endtask

    task automatic wait_rsp(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 120; c++) begin
        if (rsp_k.size() > n) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
    endtask

    initial begin
      int k0, g0, n0;
      done = 1'b0;
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
      l0 = 8'd0; r0 = 8'd0; o0 = 8'd0; l1 = 8'd0; r1 = 8'd0; o1 = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single request on port 0
      v0 = 1'b1; l0 = 8'd3; r0 = 8'd11; o0 = 8'h11; k0 = k;
      wait_fire(1'b0, got); chk("p1_accept", got, 1); v0 = 1'b0;
      wait_rsp(0, got); chk("p1_rsp_seen", got, 1);
      if (got) begin
        chk("p1_ready_same_cycle", grant_k[0], k0);
        chk("p1_latency", rsp_k[0] - grant_k[0], 5);
        chk("p1_data", rsp_dq[0], 14);
        chk("p1_id", rsp_iq[0], 0);
      end

      // Both valid out of reset, then held for six alternating grants
      rst = 1'b1;
      v0 = 1'b1; l0 = 8'd1; r0 = 8'd2; o0 = 8'h11;
      v1 = 1'b1; l1 = 8'd5; r1 = 8'd6; o1 = 8'h11;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      g0 = grant_id.size(); n0 = rsp_k.size();
      for (int n = 0; n < 200 && grant_id.size() < g0 + 6; n++) begin
        @(posedge clk); #1;
        if (fired0) begin l0 = 8'($urandom_range(0, 255)); r0 = 8'($urandom_range(0, 255)); end
        if (fired1) begin l1 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255)); end
      end
      v0 = 1'b0; v1 = 1'b0;
      chk("fair_count", grant_id.size() - g0, 6);
      for (int i = 0; i < 6 && g0 + i < grant_id.size(); i++) chk("fair_order", grant_id[g0 + i], i % 2);
      wait_rsp(n0 + 5, got); chk("sim_rsp_seen", got, 1);
      if (got) begin
        chk("sim_data0", rsp_dq[n0], 3);
        chk("sim_id0", rsp_iq[n0], 0);
        chk("sim_data1", rsp_dq[n0 + 1], 11);
        chk("sim_id1", rsp_iq[n0 + 1], 1);
        chk("sim_gap", rsp_k[n0 + 1] - rsp_k[n0], 6);
      end

      // Reset in the middle of the strobe window
      v0 = 1'b1; l0 = 8'd9; r0 = 8'd9; o0 = 8'h11;
      wait_fire(1'b0, got); chk("rm_accept", got, 1); v0 = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk); #1;
        if (ck_l) begin got = 1'b1; break; end
      end
      chk("rm_strobe_seen", got, 1);
      n0 = rsp_k.size();
      #3 rst = 1'b1;
      #1 chk("rm_async_clear", {ck_l, ck_r, ck_o, busy, rsp_v}, 0);
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      chk("rm_no_rsp", rsp_k.size(), n0);
      g0 = grant_id.size();
      v0 = 1'b1; l0 = 8'd7; r0 = 8'd1; o0 = 8'h11;
      v1 = 1'b1; l1 = 8'd2; r1 = 8'd4; o1 = 8'h5a;
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk); #1;
        if (grant_id.size() > g0) begin got = 1'b1; break; end
      end
      chk("rm_grant_seen", got, 1);
      if (got) chk("rm_first_grant", grant_id[g0], 0);
      if (fired0) v0 = 1'b0;
      if (fired1) v1 = 1'b0;

      // Random traffic with small operand ranges so triples repeat
      for (int n = 0; n < 400; n++) begin
        @(posedge clk); #1;
        if (fired0) v0 = 1'b0;
        if (fired1) v1 = 1'b0;
        if (!v0 && $urandom_range(0, 1) == 1) begin
          v0 = 1'b1; l0 = 8'($urandom_range(0, 3)); r0 = 8'($urandom_range(0, 3));
          o0 = ($urandom_range(0, 1) == 1) ? 8'h11 : 8'h5a;
        end else if (v0 && !fired0 && $urandom_range(0, 15) == 0) begin
          v0 = 1'b0;
        end
        if (!v1 && $urandom_range(0, 1) == 1) begin
          v1 = 1'b1; l1 = 8'($urandom_range(0, 3)); r1 = 8'($urandom_range(0, 3));
          o1 = ($urandom_range(0, 1) == 1) ? 8'h11 : 8'h5a;
        end else if (v1 && !fired1 && $urandom_range(0, 15) == 0) begin
          v1 = 1'b0;
        end
      end
      v0 = 1'b0; v1 = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Same triple twice on port 1; the repeat is a cache hit when the cache is built in
      for (int rep = 0; rep < 2; rep++) begin
        n0 = rsp_k.size();
        v1 = 1'b1; l1 = 8'd3; r1 = 8'd11; o1 = 8'h11;
        wait_fire(1'b1, got); chk("rep_accept", got, 1); v1 = 1'b0;
        wait_rsp(n0, got); chk("rep_rsp_seen", got, 1);
        if (got) begin
          chk("rep_data", rsp_dq[n0], 14);
          chk("rep_id", rsp_iq[n0], 1);
`ifdef ALU_REQ_CACHE_EN
          if (rep == 1) chk("rep_latency", rsp_k[n0] - grant_k[grant_k.size() - 1], 1);
`else
          if (rep == 1) chk("rep_latency", rsp_k[n0] - grant_k[grant_k.size() - 1], 5);
`endif
        end
        repeat (3) @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    for (int n = 0; n < 30000; n++) begin
      @(posedge clk);
      if (inst[0].done && inst[1].done) break;
    end
    #5;
    chk("all_phases_done", {30'd0, inst[1].done, inst[0].done}, 32'd3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
